segway_auth_rx: RTL and testbench
=================================

SEGWAY_AUTH_RX -- requirements
Module: segway_auth_rx

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clk cycles per UART bit (50 MHz / 9600 baud).
REQ-002 Parameter MIN_RIDER_WT, default 12'h200, summed load-cell threshold for rider present.
REQ-003 Parameter WT_HYST, default 12'h040, hysteresis below MIN_RIDER_WT for declaring rider off.
REQ-004 clk  in  1  system clock; the block uses one clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 RX  in  1  asynchronous serial line from the BLE module; idles high.
REQ-007 lft_ld  in  12  left load-cell A2D value.
REQ-008 rght_ld  in  12  right load-cell A2D value.
REQ-009 ld_vld  in  1  one-cycle strobe; lft_ld and rght_ld are valid this cycle.
REQ-010 pwr_up  out  1  authorization to the balance controller; high enables drive.
REQ-011 rider_off  out  1  registered rider-absent flag.
REQ-012 cmd_err  out  1  one-cycle pulse when a received byte is neither 'G' nor 'S'.
REQ-013 frm_err  out  1  one-cycle pulse when a stop bit samples low.

Function
REQ-014 RX SHALL pass through a 2-flop synchronizer, preset high, before any use.
REQ-015 Receiver in IDLE SHALL start a frame on a high-to-low transition of the synchronized RX.
REQ-016 Receiver SHALL sample start bit at BAUD_DIV/2 cycles after the edge, then each subsequent bit every BAUD_DIV cycles: 8 data bits LSB first, then the stop bit.
REQ-017 A start bit sampled high SHALL be treated as a glitch: return to IDLE, no byte, no error.
REQ-018 Stop bit high SHALL yield an internal one-cycle byte-ready strobe with the byte; stop bit low SHALL pulse frm_err and discard the byte.
REQ-019 Receiver SHALL return to IDLE on the cycle after the stop-bit sample and accept a new start edge immediately.
REQ-020 On ld_vld, a 13-bit sum lft_ld+rght_ld (no overflow) SHALL be evaluated; the sum SHALL be unaffected by inputs outside ld_vld cycles.
REQ-021 rider_off SHALL set on ld_vld when sum < MIN_RIDER_WT-WT_HYST, and clear on ld_vld when sum >= MIN_RIDER_WT; otherwise hold.
REQ-022 Auth FSM states: OFF, PWR1, PWR2.
REQ-023 OFF: byte 'G' (8'h47) -> PWR1; all else stay.
REQ-024 PWR1: byte 'S' (8'h53) -> OFF if rider_off high, else PWR2; all else stay.
REQ-025 PWR2: rider_off high -> OFF; byte 'G' -> PWR1; all else stay.
REQ-026 FSM SHALL use the registered rider_off value from before the current cycle when a byte and a rider_off update coincide.
REQ-027 pwr_up SHALL be registered, high exactly when next state is PWR1 or PWR2, i.e. one cycle after the byte-ready strobe.
REQ-028 Any byte other than 'G' or 'S' SHALL pulse cmd_err on the same cycle pwr_up would update, with no state change.
REQ-029 Back-to-back bytes SHALL each be processed; no byte SHALL be lost.

Reset
REQ-030 rst SHALL force: receiver IDLE, synchronizer high, FSM OFF, pwr_up 0, rider_off 1, cmd_err 0, frm_err 0.
REQ-031 rst asserted mid-frame SHALL abort the frame; no strobe or error for that frame after release.

Structure
REQ-032 A shared package segway_auth_pkg SHALL hold the FSM state enum, the 'G'/'S' command constants, and the parameter defaults.
REQ-033 The receiver SHALL be a sub-module auth_uart_rx (clk, rst, RX, rx_data, rx_rdy, frm_err); FSM and weight logic stay in segway_auth_rx.

Verification
REQ-034 Loads 330/320 on ld_vld, send 'G' -> rider_off 0, pwr_up 1 within BAUD_DIV*10+4 cycles of start edge.
REQ-035 In PWR1 with loads 330/320, send 'S' -> state PWR2, pwr_up stays 1; then loads 100/100 on ld_vld -> pwr_up 0 next cycle.
REQ-036 Loads 0x1E0 total (between thresholds) after being 0x280 -> rider_off stays 0; then 0x1B0 -> rider_off 1.
REQ-037 Send 8'h41 in OFF -> cmd_err one-cycle pulse, pwr_up stays 0; send frame with stop bit 0 -> frm_err pulse, no state change.
REQ-038 1-bit-time-short low glitch (BAUD_DIV/4 cycles) on RX -> no byte, no errors; then valid 'G' received correctly.
REQ-039 Assert rst during data bit 4 of 'G', release, send 'G' -> exactly one transition OFF->PWR1, no spurious errors.

Source files
------------

// File: rtl/segway_auth_pkg.sv
// Shared types and constants for the Segway authorization receiver.
package segway_auth_pkg;

    // Parameter defaults: 50 MHz clock at 9600 baud, load-cell thresholds.
    localparam int          BAUD_DIV_DEF     = 5208;
    localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
    localparam logic [11:0] WT_HYST_DEF      = 12'h040;

    // Command bytes from the BLE module.
    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'
    localparam logic [7:0] CMD_STOP = 8'h53;  // 'S'

    // Authorization state machine.
    typedef enum logic [1:0] {
        OFF,
        PWR1,
        PWR2
    } auth_state_t;

    // UART receiver framing state.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/segway_auth_rx_uart.sv
// 8N1 UART receiver: synchronizes RX, finds the start edge, samples each bit
// mid-cell and reports either a good byte (rx_rdy) or a framing error.
module auth_uart_rx
    import segway_auth_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err
);

    localparam int               CNT_W     = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

    logic             rx_meta, rx_sync, rx_prev;
    logic             start_edge, bit_tick;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, cnt_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             rdy_nxt, ferr_nxt;

    // Two-flop synchronizer (preset to idle-high) plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;
    assign bit_tick   = (baud_cnt == ((state == START) ? HALF_LAST : FULL_LAST));
    assign rx_data    = shift;

    // Next-state and bit-sampling decisions for the frame currently on the line.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal; a missed path would infer a latch.
        state_nxt = state;
        cnt_nxt   = baud_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        rdy_nxt   = 1'b0;
        ferr_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_edge) state_nxt = START;
            end
            START: if (bit_tick) begin
                cnt_nxt   = '0;
                bit_nxt   = '0;
                // A start bit that is high again mid-cell was only a glitch.
                state_nxt = rx_sync ? IDLE : DATA;
            end
            DATA: if (bit_tick) begin
                cnt_nxt   = '0;
                shift_nxt = {rx_sync, shift[7:1]};
                bit_nxt   = bit_cnt + 1'b1;
                if (bit_cnt == 3'd7) state_nxt = STOP;
            end
            STOP: if (bit_tick) begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
                rdy_nxt   = rx_sync;
                ferr_nxt  = ~rx_sync;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Framing state, counters, shift register and result strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_rdy   <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= cnt_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            rx_rdy   <= rdy_nxt;
            frm_err  <= ferr_nxt;
        end
    end

endmodule

// File: rtl/segway_auth_rx.sv
// Segway power authorization: decodes 'G'/'S' commands from the BLE UART and
// combines them with a hysteretic rider-present flag from the load cells.
module segway_auth_rx
    import segway_auth_pkg::*;
#(
    parameter int          BAUD_DIV     = BAUD_DIV_DEF,
    parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYST      = WT_HYST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        ld_vld,
    output logic        pwr_up,
    output logic        rider_off,
    output logic        cmd_err,
    output logic        frm_err
);

    localparam logic [12:0] ON_THR  = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0] OFF_THR = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic [12:0] ld_sum;
    logic        is_go, is_stop;
    auth_state_t state, state_nxt;

    auth_uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_rx (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .frm_err (frm_err)
    );

    assign ld_sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign is_go   = rx_rdy && (rx_data == CMD_GO);
    assign is_stop = rx_rdy && (rx_data == CMD_STOP);

    // Rider-present flag with hysteresis, updated only on a valid load sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            rider_off <= 1'b1;
        end else if (ld_vld) begin
            if (ld_sum < OFF_THR)       rider_off <= 1'b1;
            else if (ld_sum >= ON_THR)  rider_off <= 1'b0;
        end
    end

    // Authorization next state; rider_off is the value registered before this cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            OFF:  if (is_go) state_nxt = PWR1;
            PWR1: if (is_stop) state_nxt = rider_off ? OFF : PWR2;
            PWR2: begin
                if (rider_off)  state_nxt = OFF;
                else if (is_go) state_nxt = PWR1;
            end
            default: state_nxt = OFF;
        endcase
    end

    // State register, registered authorization and unknown-command pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OFF;
            pwr_up  <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            pwr_up  <= (state_nxt != OFF);
            cmd_err <= rx_rdy && !is_go && !is_stop;
        end
    end

endmodule

// File: tb/tb_segway_auth_rx.sv
// Self-checking bench for segway_auth_rx: a frame-level model predicts every
// output each cycle, plus directed literal checks at key points.
module tb_segway_auth_rx;

    localparam int B        = 16;
    localparam int HALF     = B / 2;
    // Posedges from driving the start bit low until the receiver reports the byte.
    localparam int DONE_LAT = 3 + HALF + 9 * B;
    localparam int MIN_WT   = 'h200;
    localparam int HYST     = 'h040;
    localparam logic [7:0] GO   = 8'h47;
    localparam logic [7:0] STOPC = 8'h53;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        ld_vld = 1'b0;
    logic        pwr_up, rider_off, cmd_err, frm_err;

    segway_auth_rx #(
        .BAUD_DIV     (B),
        .MIN_RIDER_WT (12'h200),
        .WT_HYST      (12'h040)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .ld_vld    (ld_vld),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .cmd_err   (cmd_err),
        .frm_err   (frm_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         done_cyc;
        logic [7:0] data;
        logic       ok;
    } frame_ev_t;

    typedef enum {M_OFF, M_PWR1, M_PWR2} mstate_t;

    frame_ev_t  evq[$];
    frame_ev_t  ev;
    int         cyc = 0;
    bit         model_on = 0;
    mstate_t    m_state = M_OFF;
    logic       m_pwr_up = 1'b0, m_rider_off = 1'b1, m_cmd_err = 1'b0, m_frm_err = 1'b0;
    bit         pend_vld = 0;
    logic [7:0] pend_byte = '0;
    bit         bv;
    logic [7:0] bval;
    int         sum;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_on    = 1;
            m_state     = M_OFF;
            m_pwr_up    = 1'b0;
            m_rider_off = 1'b1;
            m_cmd_err   = 1'b0;
            m_frm_err   = 1'b0;
            pend_vld    = 0;
            evq.delete();
        end else begin
            // A byte reported by the receiver is acted on at the following edge.
            bv       = pend_vld;
            bval     = pend_byte;
            pend_vld = 0;
            m_cmd_err = bv && (bval != GO) && (bval != STOPC);
            case (m_state)
                M_OFF:  if (bv && bval == GO) m_state = M_PWR1;
                M_PWR1: if (bv && bval == STOPC) m_state = m_rider_off ? M_OFF : M_PWR2;
                M_PWR2: begin
                    if (m_rider_off)            m_state = M_OFF;
                    else if (bv && bval == GO)  m_state = M_PWR1;
                end
                default: m_state = M_OFF;
            endcase
            m_pwr_up = (m_state != M_OFF);
            if (ld_vld) begin
                sum = int'(lft_ld) + int'(rght_ld);
                if (sum < MIN_WT - HYST) m_rider_off = 1'b1;
                else if (sum >= MIN_WT)  m_rider_off = 1'b0;
            end
            m_frm_err = 1'b0;
            if (evq.size() > 0 && evq[0].done_cyc == cyc) begin
                ev = evq.pop_front();
                if (ev.ok) begin
                    pend_vld  = 1;
                    pend_byte = ev.data;
                end else begin
                    m_frm_err = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on) begin
            check("pwr_up",    pwr_up,    m_pwr_up);
            check("rider_off", rider_off, m_rider_off);
            check("cmd_err",   cmd_err,   m_cmd_err);
            check("frm_err",   frm_err,   m_frm_err);
        end
    end

    // Event counters for windowed directed checks.
    int   n_cmd = 0, n_frm = 0, n_rise = 0, rise_cyc = -1;
    logic pwr_prev = 1'b0;

    always @(negedge clk) begin
        if (cmd_err === 1'b1) n_cmd++;
        if (frm_err === 1'b1) n_frm++;
        if (pwr_up === 1'b1 && pwr_prev !== 1'b1) begin
            n_rise++;
            rise_cyc = cyc;
        end
        pwr_prev = pwr_up;
    end

    // ---------------- stimulus ----------------
    int t_start = 0;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        n_cmd    = 0;
        n_frm    = 0;
        n_rise   = 0;
        rise_cyc = -1;
    endtask

    task automatic load(input logic [11:0] l, input logic [11:0] r);
        @(negedge clk);
        lft_ld  = l;
        rght_ld = r;
        ld_vld  = 1'b1;
        @(negedge clk);
        ld_vld  = 1'b0;
        lft_ld  = 12'($urandom);
        rght_ld = 12'($urandom);
    endtask

    // Sends one 8N1 frame; abort_bit >= 0 resets the DUT mid-way through that data bit.
    task automatic send(input logic [7:0] d, input logic stop, input int abort_bit);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = frame[i];
            if (i == 0) begin
                t_start = cyc;
                evq.push_back('{done_cyc: cyc + DONE_LAT, data: d, ok: stop});
            end
            if (abort_bit >= 0 && i - 1 == abort_bit) begin
                repeat (HALF) @(negedge clk);
                rst = 1'b1;
                RX  = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                return;
            end
            repeat (B - 1) @(negedge clk);
        end
        if (!stop) begin
            @(negedge clk);
            RX = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        RX  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pwr_up",    pwr_up,    0);
        check("rst_rider_off", rider_off, 1);
        check("rst_cmd_err",   cmd_err,   0);
        check("rst_frm_err",   frm_err,   0);
        rst = 1'b0;
        idle(2);

        // Rider on, then 'G' authorizes.
        load(12'd330, 12'd320);
        check("rider_on_650", rider_off, 0);
        clear_counts();
        send(GO, 1'b1, -1);
        idle(6);
        check("G_pwr_up",        pwr_up, 1);
        check("G_latency",       rise_cyc - t_start, DONE_LAT + 1);
        check("G_latency_bound", ((rise_cyc - t_start) <= 10 * B + 4) ? 1 : 0, 1);

        // 'S' with rider on -> PWR2; rider steps off -> drop.
        send(STOPC, 1'b1, -1);
        idle(6);
        check("S_pwr2_pwr_up", pwr_up, 1);
        load(12'd100, 12'd100);
        check("light_rider_off", rider_off, 1);
        check("light_pwr_still", pwr_up, 1);
        @(negedge clk);
        check("pwr2_drop", pwr_up, 0);

        // Hysteresis band and exact thresholds.
        load(12'h140, 12'h140);
        check("sum_280", rider_off, 0);
        load(12'h0F0, 12'h0F0);
        check("sum_1E0_hold", rider_off, 0);
        load(12'h0D8, 12'h0D8);
        check("sum_1B0_set", rider_off, 1);
        load(12'h100, 12'h0C0);
        check("sum_1C0_hold1", rider_off, 1);
        load(12'h100, 12'h100);
        check("sum_200_clear", rider_off, 0);
        load(12'h0E0, 12'h0E0);
        check("sum_1C0_hold0", rider_off, 0);
        load(12'h0E0, 12'h0DF);
        check("sum_1BF_set", rider_off, 1);
        load(12'hFFF, 12'hFFF);
        check("sum_1FFE_clear", rider_off, 0);
        load(12'h000, 12'h000);
        check("sum_0_set", rider_off, 1);

        // Unknown command and framing error in OFF.
        clear_counts();
        send(8'h41, 1'b1, -1);
        idle(4);
        check("A_cmd_err_cnt", n_cmd, 1);
        check("A_pwr_up",      pwr_up, 0);
        clear_counts();
        send(GO, 1'b0, -1);
        idle(4);
        check("frm_err_cnt", n_frm, 1);
        check("frm_cmd_cnt", n_cmd, 0);
        check("frm_pwr_up",  pwr_up, 0);

        // Short glitch, then back-to-back 'G','S' with rider off.
        clear_counts();
        @(negedge clk);
        RX = 1'b0;
        repeat (B / 4) @(negedge clk);
        RX = 1'b1;
        idle(2 * B);
        check("glitch_frm", n_frm, 0);
        check("glitch_cmd", n_cmd, 0);
        check("glitch_pwr", pwr_up, 0);
        send(GO, 1'b1, -1);
        send(STOPC, 1'b1, -1);
        idle(6);
        check("b2b_GS_rises", n_rise, 1);
        check("b2b_GS_pwr",   pwr_up, 0);

        // Back-to-back bad byte then 'G'.
        clear_counts();
        send(8'h41, 1'b1, -1);
        send(GO, 1'b1, -1);
        idle(6);
        check("b2b_AG_cmd", n_cmd, 1);
        check("b2b_AG_pwr", pwr_up, 1);

        // Reset during data bit 4 of 'G', then a clean 'G'.
        send(GO, 1'b1, 4);
        check("abort_pwr_up",    pwr_up,    0);
        check("abort_rider_off", rider_off, 1);
        clear_counts();
        idle(2 * B);
        send(GO, 1'b1, -1);
        idle(6);
        check("post_rst_rises", n_rise, 1);
        check("post_rst_cmd",   n_cmd,  0);
        check("post_rst_frm",   n_frm,  0);
        check("post_rst_pwr",   pwr_up, 1);

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
